// File: rtl/rdoq_level_selector.sv
// RDOQ level selector: walks candidate levels through the CABAC rate
// estimator and keeps the level with the lowest RD cost.
module rdoq_level_selector #(
  parameter int RATE_FRAC   = 15,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] max_abs_level,
  input  logic [31:0] level_double,
  input  logic [4:0]  q_bits,
  input  logic [31:0] lambda,
  input  logic [31:0] zero_rate,
  output logic        est_start,
  output logic [15:0] est_abs_level,
  input  logic [31:0] est_irate,
  input  logic        est_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] best_level,
  output logic [63:0] best_cost,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ISSUE, S_WAIT, S_EVAL, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [15:0]   max_q, cand, min_abs;
  logic [31:0]   lvl_q, lam_q, zr_q, irate_q;
  logic [4:0]    qb_q;
  logic [CW-1:0] wait_cnt;
  logic          last, tmo;

  logic [47:0] shf, dif, err_sq;
  logic [23:0] err;
  logic [63:0] rate_t, cost, e0_sq, zr_t, cost0;
  logic [64:0] sum, sum0;

  assign last = (cand == min_abs);
  assign tmo  = (state == S_WAIT) && !est_done
             && (wait_cnt == CW'(TIMEOUT_CYC - 1));

  // candidate cost: saturated |error|^2 plus scaled rate
  always_comb begin
    shf    = {32'd0, cand} << qb_q;
    dif    = ({16'd0, lvl_q} >= shf) ? {16'd0, lvl_q} - shf
                                     : shf - {16'd0, lvl_q};
    err    = (|dif[47:24]) ? 24'hFF_FFFF : dif[23:0];
    err_sq = {24'd0, err} * {24'd0, err};
    rate_t = ({32'd0, lam_q} * {32'd0, irate_q}) >> RATE_FRAC;
    sum    = {17'd0, err_sq} + {1'b0, rate_t};
    cost   = sum[64] ? '1 : sum[63:0];
    e0_sq  = {32'd0, lvl_q} * {32'd0, lvl_q};
    zr_t   = ({32'd0, lam_q} * {32'd0, zr_q}) >> RATE_FRAC;
    sum0   = {1'b0, e0_sq} + {1'b0, zr_t};
    cost0  = sum0[64] ? '1 : sum0[63:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_nx = S_INIT;
      S_INIT:  state_nx = (max_q == 16'd0) ? S_DONE : S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (est_done) state_nx = S_EVAL;
        else if (tmo) state_nx = last ? S_DONE : S_ISSUE;
      end
      S_EVAL:  state_nx = last ? S_DONE : S_ISSUE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = rst_n && (state == S_IDLE);
    est_start     = (state == S_ISSUE);
    out_valid     = (state == S_DONE);
    est_abs_level = 16'd0;
    if (state == S_ISSUE || state == S_WAIT || state == S_EVAL)
      est_abs_level = cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q       <= '0;
      lvl_q       <= '0;
      qb_q        <= '0;
      lam_q       <= '0;
      zr_q        <= '0;
      irate_q     <= '0;
      cand        <= '0;
      min_abs     <= '0;
      wait_cnt    <= '0;
      best_level  <= '0;
      best_cost   <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (in_valid) begin
          max_q <= max_abs_level;
          lvl_q <= level_double;
          qb_q  <= q_bits;
          lam_q <= lambda;
          zr_q  <= zero_rate;
        end
        S_INIT: begin
          best_level <= '0;
          best_cost  <= cost0;
          cand       <= max_q;
          min_abs    <= (max_q > 16'd1) ? max_q - 16'd1 : 16'd1;
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          if (est_done) begin
            irate_q <= est_irate;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            if (!last) cand <= cand - 16'd1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_EVAL: begin
          // strict compare: earlier (higher or zero) level wins ties
          if (cost < best_cost) begin
            best_level <= cand;
            best_cost  <= cost;
          end
          if (!last) cand <= cand - 16'd1;
        end
        S_DONE: if (out_ready) timeout_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rdoq_level_selector.sv
// Directed bench for rdoq_level_selector with a fixed-latency
// estimator stub (L=3, iRate = bits * 32768).
module tb_rdoq_level_selector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] max_abs_level;
  logic [31:0] level_double;
  logic [4:0]  q_bits;
  logic [31:0] lambda;
  logic [31:0] zero_rate;
  logic        est_start;
  logic [15:0] est_abs_level;
  logic [31:0] est_irate;
  logic        est_done;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] best_level;
  logic [63:0] best_cost;
  logic        timeout_err;

  int n_chk = 0;
  int n_fail = 0;

  rdoq_level_selector dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .max_abs_level(max_abs_level), .level_double(level_double),
    .q_bits(q_bits), .lambda(lambda), .zero_rate(zero_rate),
    .est_start(est_start), .est_abs_level(est_abs_level),
    .est_irate(est_irate), .est_done(est_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .best_level(best_level), .best_cost(best_cost),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // estimator stub
  int          stub_bits [0:15];
  logic        stub_en = 1'b1;
  int          stub_cnt = 0;
  logic [15:0] stub_lvl = '0;
  int          n_start = 0;
  logic [15:0] lvl_log [0:7];

  always @(posedge clk) begin
    if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
    if (est_start) begin
      stub_cnt <= 3;
      stub_lvl <= est_abs_level;
      if (n_start < 8) lvl_log[n_start] <= est_abs_level;
      n_start <= n_start + 1;
    end
  end

  assign est_done  = stub_en && (stub_cnt == 1);
  assign est_irate = est_done ? (32'(stub_bits[stub_lvl[3:0]]) << 15) : 32'd0;

  task automatic run_req(input logic [15:0] ma, input logic [31:0] ld,
                         input logic [4:0] qb, input logic [31:0] lam,
                         input logic [31:0] zr, output int lat);
    n_start       = 0;
    max_abs_level = ma;
    level_double  = ld;
    q_bits        = qb;
    lambda        = lam;
    zero_rate     = zr;
    in_valid      = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 600) begin
      @(posedge clk); #1;
      lat++;
    end
    n_chk++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL run_bound: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  task automatic accept_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({in_ready, est_start, est_abs_level, out_valid, best_level, best_cost, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%0b st=%0b lvl=%0d ov=%0b bl=%0d bc=%0d te=%0b, required all 0",
               in_ready, est_start, est_abs_level, out_valid, best_level, best_cost, timeout_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
  endtask

  task automatic test_multi_candidate();
    int lat;
    stub_bits[3] = 5;
    stub_bits[2] = 4;
    run_req(16'd3, 32'd2662, 5'd10, 32'd10000, 32'd32768, lat);
    n_chk++;
    if (lat !== 12) begin
      n_fail++;
      $display("FAIL multi_latency: got %0d, required 12", lat);
    end
    n_chk++;
    if (n_start !== 2 || lvl_log[0] !== 16'd3 || lvl_log[1] !== 16'd2) begin
      n_fail++;
      $display("FAIL multi_levels: starts=%0d l0=%0d l1=%0d, required 2/3/2",
               n_start, lvl_log[0], lvl_log[1]);
    end
    n_chk++;
    if (best_level !== 16'd3 || best_cost !== 64'd218100 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_result: level=%0d cost=%0d te=%0b, required 3/218100/0",
               best_level, best_cost, timeout_err);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          best_level !== 16'd3 || best_cost !== 64'd218100) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: ov=%0b rdy=%0b level=%0d cost=%0d, required 1/0/3/218100",
                 i, out_valid, in_ready, best_level, best_cost);
      end
    end
    accept_result();
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: ov=%0b rdy=%0b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero_level();
    int lat;
    run_req(16'd0, 32'd100, 5'd10, 32'd10000, 32'd32768, lat);
    n_chk++;
    if (lat !== 2 || n_start !== 0) begin
      n_fail++;
      $display("FAIL zero_latency: lat=%0d starts=%0d, required 2/0", lat, n_start);
    end
    n_chk++;
    if (best_level !== 16'd0 || best_cost !== 64'd20000) begin
      n_fail++;
      $display("FAIL zero_result: level=%0d cost=%0d, required 0/20000", best_level, best_cost);
    end
    accept_result();
  endtask

  task automatic test_single();
    int lat;
    stub_bits[1] = 20;
    run_req(16'd1, 32'd200, 5'd10, 32'd10000, 32'd32768, lat);
    n_chk++;
    if (lat !== 7 || n_start !== 1 || lvl_log[0] !== 16'd1) begin
      n_fail++;
      $display("FAIL single_seq: lat=%0d starts=%0d l0=%0d, required 7/1/1", lat, n_start, lvl_log[0]);
    end
    n_chk++;
    if (best_level !== 16'd0 || best_cost !== 64'd50000) begin
      n_fail++;
      $display("FAIL single_result: level=%0d cost=%0d, required 0/50000", best_level, best_cost);
    end
    accept_result();
  endtask

  task automatic test_tie();
    int lat;
    stub_bits[2] = 7;
    stub_bits[1] = 7;
    run_req(16'd2, 32'd1536, 5'd10, 32'd0, 32'd32768, lat);
    n_chk++;
    if (best_level !== 16'd2 || best_cost !== 64'd262144 || lat !== 12) begin
      n_fail++;
      $display("FAIL tie_result: level=%0d cost=%0d lat=%0d, required 2/262144/12",
               best_level, best_cost, lat);
    end
    accept_result();
  endtask

  task automatic test_timeout();
    int lat;
    stub_en = 1'b0;
    run_req(16'd2, 32'd2662, 5'd10, 32'd10000, 32'd32768, lat);
    n_chk++;
    if (timeout_err !== 1'b1 || best_level !== 16'd0 ||
        best_cost !== 64'd7096244 || n_start !== 2) begin
      n_fail++;
      $display("FAIL timeout_result: te=%0b level=%0d cost=%0d starts=%0d, required 1/0/7096244/2",
               timeout_err, best_level, best_cost, n_start);
    end
    accept_result();
    n_chk++;
    if (timeout_err !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: te=%0b ov=%0b, required 0/0", timeout_err, out_valid);
    end
    stub_en = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    stub_bits[3] = 5;
    stub_bits[2] = 4;
    n_start       = 0;
    max_abs_level = 16'd3;
    level_double  = 32'd2662;
    q_bits        = 5'd10;
    lambda        = 32'd10000;
    zero_rate     = 32'd32768;
    in_valid      = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({in_ready, est_start, est_abs_level, out_valid, best_level, best_cost, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: rdy=%0b st=%0b lvl=%0d ov=%0b bl=%0d bc=%0d te=%0b, required all 0",
               in_ready, est_start, est_abs_level, out_valid, best_level, best_cost, timeout_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || n_start !== 1 || est_abs_level !== 16'd0) begin
      n_fail++;
      $display("FAIL midreset_idle: rdy=%0b ov=%0b starts=%0d lvl=%0d, required 1/0/1/0",
               in_ready, out_valid, n_start, est_abs_level);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_req(16'd3, 32'd2662, 5'd10, 32'd10000, 32'd32768, lat);
    n_chk++;
    if (lat !== 12 || best_level !== 16'd3 || best_cost !== 64'd218100) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d level=%0d cost=%0d, required 12/3/218100",
               lat, best_level, best_cost);
    end
    accept_result();
    run_req(16'd0, 32'd100, 5'd10, 32'd10000, 32'd32768, lat);
    n_chk++;
    if (lat !== 2 || best_level !== 16'd0 || best_cost !== 64'd20000) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d level=%0d cost=%0d, required 2/0/20000",
               lat, best_level, best_cost);
    end
    accept_result();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) stub_bits[i] = 0;
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    max_abs_level = '0;
    level_double  = '0;
    q_bits        = '0;
    lambda        = '0;
    zero_rate     = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_multi_candidate();
    test_hold();
    test_zero_level();
    test_single();
    test_tie();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
